// File: rtl/ctl_reg_commit_sequencer.sv
// Debounces a software control word, offers it downstream over valid/ready,
// and turns a committed arm bit into a single start pulse on the next sync.
module ctl_reg_commit_sequencer #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       ctl_word,
   input  logic              sync_in,
   input  logic              cfg_ready,
   output logic              cfg_valid,
   output logic              cfg_enable,
   output logic [7:0]        cfg_port,
   output logic [15:0]       cfg_len,
   output logic              armed,
   output logic              start_pulse,
   output logic [CNT_W-1:0]  commit_cnt,
   output logic              len_err
);

   localparam int SW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;

   state_t            state_q, state_d;
   logic [31:0]       ctl_q;
   logic [31:0]       commit_q, commit_d;
   logic [31:0]       shadow_q, shadow_d;
   logic [SW-1:0]     stable_q, stable_d;
   logic              cfg_enable_q, cfg_enable_d;
   logic [7:0]        cfg_port_q, cfg_port_d;
   logic [15:0]       cfg_len_q, cfg_len_d;
   logic              armed_q, armed_d;
   logic              start_q, start_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              len_err_q, len_err_d;
   logic              chg;
   logic              accept;

   assign chg    = (ctl_word != ctl_q);
   assign accept = (state_q == COMMIT) && cfg_ready;

   always_comb begin
      state_d      = state_q;
      commit_d     = commit_q;
      shadow_d     = shadow_q;
      stable_d     = stable_q;
      cfg_enable_d = cfg_enable_q;
      cfg_port_d   = cfg_port_q;
      cfg_len_d    = cfg_len_q;
      cnt_d        = cnt_q;
      len_err_d    = len_err_q;
      case (state_q)
         IDLE: begin
            if (ctl_word != commit_q) begin
               state_d  = SETTLE;
               stable_d = SW'(1);
            end
         end
         SETTLE: begin
            // Any change restarts the stability window; a settled word is
            // dropped if it reverted, absorbed if its length is zero.
            if (chg) begin
               stable_d = SW'(1);
            end else if (stable_q == SW'(STABLE_CYCLES)) begin
               if (ctl_q == commit_q) begin
                  state_d = IDLE;
               end else if (ctl_q[31:16] == 16'h0000) begin
                  len_err_d = 1'b1;
                  commit_d  = ctl_q;
                  state_d   = IDLE;
               end else begin
                  shadow_d = ctl_q;
                  state_d  = COMMIT;
               end
            end else begin
               stable_d = stable_q + 1'b1;
            end
         end
         COMMIT: begin
            if (cfg_ready) begin
               commit_d     = shadow_q;
               cfg_enable_d = shadow_q[0];
               cfg_port_d   = shadow_q[15:8];
               cfg_len_d    = shadow_q[31:16];
               cnt_d        = cnt_q + 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arm follows edges of the committed arm bit; only an already-armed sync fires.
   always_comb begin
      armed_d = armed_q;
      start_d = 1'b0;
      if (armed_q && sync_in) begin
         start_d = 1'b1;
         armed_d = 1'b0;
      end
      if (accept && shadow_q[1] && !commit_q[1]) begin
         armed_d = 1'b1;
      end else if (accept && !shadow_q[1] && commit_q[1]) begin
         armed_d = 1'b0;
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q      <= IDLE;
         ctl_q        <= '0;
         commit_q     <= '0;
         shadow_q     <= '0;
         stable_q     <= '0;
         cfg_enable_q <= 1'b0;
         cfg_port_q   <= '0;
         cfg_len_q    <= '0;
         armed_q      <= 1'b0;
         start_q      <= 1'b0;
         cnt_q        <= '0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ctl_q        <= ctl_word;
         commit_q     <= commit_d;
         shadow_q     <= shadow_d;
         stable_q     <= stable_d;
         cfg_enable_q <= cfg_enable_d;
         cfg_port_q   <= cfg_port_d;
         cfg_len_q    <= cfg_len_d;
         armed_q      <= armed_d;
         start_q      <= start_d;
         cnt_q        <= cnt_d;
         len_err_q    <= len_err_d;
      end
   end

   assign cfg_valid   = (state_q == COMMIT);
   assign cfg_enable  = cfg_enable_q;
   assign cfg_port    = cfg_port_q;
   assign cfg_len     = cfg_len_q;
   assign armed       = armed_q;
   assign start_pulse = start_q;
   assign commit_cnt  = cnt_q;
   assign len_err     = len_err_q;

endmodule
